// File: rtl/sr_bank_arbiter.sv
// sr_bank_arbiter: round-robin controller for a bank of SR flags.
// Each cycle it grants one requester and applies that requester's set/reset
// command to a single bit of the bank. An S=R=1 command is reported on err
// and is never applied, so no bit can see both set and reset at once.
module sr_bank_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [2*NREQ-1:0]         op,
  input  logic [AW*NREQ-1:0]        addr,
  output logic [NREQ-1:0]           gnt,
  output logic [(1<<AW)-1:0]        Q,
  output logic [(1<<AW)-1:0]        Q_bar,
  output logic                      err,
  output logic [$clog2(NREQ)-1:0]   err_id
);

  localparam int W  = 1 << AW;
  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr;
  logic [IW-1:0] winner;
  logic [IW-1:0] cand;
  logic [IW-1:0] ptr_next;
  logic          found;
  logic [1:0]    op_w;
  logic [AW-1:0] addr_w;
  logic [W-1:0]  q_next;
  logic          err_next;
  int            idx_int;

  // Search from ptr upward with wrap; the first active request wins and its op/addr are selected
  always_comb begin
    found   = 1'b0;
    winner  = '0;
    cand    = '0;
    idx_int = 0;
    op_w    = 2'b00;
    addr_w  = '0;
    if (!reset) begin
      for (int k = 0; k < NREQ; k++) begin
        idx_int = int'(ptr) + k;
        if (idx_int >= NREQ) idx_int = idx_int - NREQ;
        cand = IW'(idx_int);
        if (!found && req[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
      for (int k = 0; k < NREQ; k++) begin
        if (found && (winner == IW'(k))) begin
          op_w   = op[2*k +: 2];
          addr_w = addr[AW*k +: AW];
        end
      end
    end
  end

  assign gnt = found ? (NREQ'(1) << winner) : '0;

  // Decode the winner's command into the next bank value, the error flag and the advanced pointer
  always_comb begin
    q_next   = Q;
    err_next = 1'b0;
    ptr_next = ptr;
    if (found) begin
      ptr_next = (winner == IW'(NREQ-1)) ? '0 : winner + IW'(1);
      case (op_w)
        2'b10:   q_next[addr_w] = 1'b1;
        2'b01:   q_next[addr_w] = 1'b0;
        2'b11:   err_next = 1'b1;
        default: q_next = Q;
      endcase
    end
  end

  // Bank, its complement, pointer and error reporting all update together; reset overrides any grant
  always_ff @(posedge clk) begin
    if (reset) begin
      Q      <= '0;
      Q_bar  <= '1;
      ptr    <= '0;
      err    <= 1'b0;
      err_id <= '0;
    end else begin
      Q     <= q_next;
      Q_bar <= ~q_next;
      ptr   <= ptr_next;
      err   <= err_next;
      if (err_next) err_id <= winner;
    end
  end

endmodule

// File: tb/tb_sr_bank_arbiter.sv
// tb_sr_bank_arbiter: table-driven directed vectors plus hand-written
// sequences for reset with random history and reset in mid-stream.
module tb_sr_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [11:0] addr;
  logic [3:0]  gnt;
  logic [7:0]  Q;
  logic [7:0]  Q_bar;
  logic        err;
  logic [1:0]  err_id;

  int vectors;
  int miscompares;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic [7:0]  op;
    logic [11:0] addr;
    logic [3:0]  gnt;
    logic [7:0]  q;
    logic        err;
    logic [1:0]  eid;
  } vec_t;

  vec_t tbl[$];

  sr_bank_arbiter #(.NREQ(4), .AW(3)) dut (
    .clk    (clk),
    .reset  (reset),
    .req    (req),
    .op     (op),
    .addr   (addr),
    .gnt    (gnt),
    .Q      (Q),
    .Q_bar  (Q_bar),
    .err    (err),
    .err_id (err_id)
  );

  // Free-running clock, 10 time units per period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic [3:0] rq, input logic [7:0] o,
                              input logic [11:0] a, input logic [3:0] g, input logic [7:0] q,
                              input logic e, input logic [1:0] id);
    vec_t v;
    v.rst = r; v.req = rq; v.op = o; v.addr = a;
    v.gnt = g; v.q = q; v.err = e; v.eid = id;
    return v;
  endfunction

  task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic [7:0] o,
                               input logic [11:0] a);
    @(posedge clk);
    #1;
    reset = r;
    req   = rq;
    op    = o;
    addr  = a;
  endtask

  task automatic checkVal(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic checkOutput(input string name, input logic [3:0] g, input logic [7:0] q,
                             input logic e, input logic [1:0] id);
    #1;
    checkVal({name, "_gnt"},    8'(gnt),    8'(g));
    checkVal({name, "_q"},      Q,          q);
    checkVal({name, "_qbar"},   Q_bar,      ~q);
    checkVal({name, "_err"},    8'(err),    8'(e));
    checkVal({name, "_err_id"}, 8'(err_id), 8'(id));
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset = 1'b1;
    req   = '0;
    op    = '0;
    addr  = '0;

    // rst, req, op, addr | gnt, Q (state after previous edge), err, err_id
    tbl.push_back(mk(1, 4'b1111, 8'hAA, 12'o3210, 4'b0000, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 8'h02, 12'o0003, 4'b0001, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h08, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h08, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'o3210, 4'b0001, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'o3210, 4'b0010, 8'h01, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'o3210, 4'b0100, 8'h03, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'o3210, 4'b1000, 8'h07, 0, 0));
    tbl.push_back(mk(0, 4'b1111, 8'hAA, 12'o3210, 4'b0001, 8'h0F, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h0F, 0, 0));
    tbl.push_back(mk(0, 4'b1000, 8'h80, 12'o6000, 4'b1000, 8'h0F, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h4F, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h4F, 0, 0));
    tbl.push_back(mk(0, 4'b0001, 8'h02, 12'o0004, 4'b0001, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 8'h30, 12'o0400, 4'b0100, 8'h10, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h10, 1, 2));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h10, 0, 2));
    tbl.push_back(mk(0, 4'b1001, 8'hC3, 12'o0000, 4'b1000, 8'h10, 0, 2));
    tbl.push_back(mk(0, 4'b1001, 8'hC3, 12'o0000, 4'b0001, 8'h10, 1, 3));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h10, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h10, 0, 0));
    tbl.push_back(mk(1, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h10, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 8'h06, 12'o0055, 4'b0001, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 8'h06, 12'o0055, 4'b0010, 8'h20, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0011, 8'h08, 12'o0010, 4'b0001, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0010, 8'h08, 12'o0010, 4'b0010, 8'h00, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 8'h00, 12'o0000, 4'b0000, 8'h02, 0, 0));

    foreach (tbl[i]) begin
      applyStimulus(tbl[i].rst, tbl[i].req, tbl[i].op, tbl[i].addr);
      checkOutput($sformatf("row%0d", i), tbl[i].gnt, tbl[i].q, tbl[i].err, tbl[i].eid);
    end

    // Random history ending with an illegal grant, then a one-cycle reset
    for (int n = 0; n < 20; n++) begin
      applyStimulus(0, 4'($urandom_range(0, 15)), 8'($urandom), 12'($urandom));
      #1;
      checkVal($sformatf("rand%0d_qbar", n), Q_bar, ~Q);
    end
    applyStimulus(0, 4'b1000, 8'hC0, 12'o0000);
    applyStimulus(1, 4'b1111, 8'hAA, 12'o3210);
    #1;
    checkVal("rstrand_gnt", 8'(gnt), 8'h00);
    applyStimulus(0, 4'b0001, 8'h02, 12'o0003);
    checkOutput("rstrand_after", 4'b0001, 8'h00, 0, 0);
    applyStimulus(0, 4'b0000, 8'h00, 12'o0000);
    checkOutput("rstrand_q", 4'b0000, 8'h08, 0, 0);

    // Reset arriving in the same cycle as a grant to requester 1
    applyStimulus(0, 4'b0010, 8'h08, 12'o0000);
    checkOutput("mid_pre", 4'b0010, 8'h08, 0, 0);
    applyStimulus(1, 4'b0010, 8'h08, 12'o0070);
    #1;
    checkVal("mid_rst_gnt", 8'(gnt), 8'h00);
    checkVal("mid_rst_q", Q, 8'h09);
    applyStimulus(0, 4'b0011, 8'h0A, 12'o0072);
    checkOutput("mid_rel0", 4'b0001, 8'h00, 0, 0);
    applyStimulus(0, 4'b0010, 8'h0A, 12'o0072);
    checkOutput("mid_rel1", 4'b0010, 8'h04, 0, 0);
    applyStimulus(0, 4'b0000, 8'h00, 12'o0000);
    checkOutput("mid_rel2", 4'b0000, 8'h84, 0, 0);

    // An illegal command pending under reset must not raise err
    applyStimulus(1, 4'b0100, 8'h30, 12'o0000);
    #1;
    checkVal("rst_illegal_gnt", 8'(gnt), 8'h00);
    applyStimulus(0, 4'b0000, 8'h00, 12'o0000);
    checkOutput("rst_illegal_after", 4'b0000, 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
